// File: rtl/led_frame_pkg.sv
// Shared types and constants for the LED frame decoder.
package led_frame_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RECV  = 2'd1,
    SYNCW = 2'd2
  } state_e;

  localparam logic [5:0] SYNC_HI      = 6'h3F;
  localparam logic [5:0] SYNC_LO      = 6'h00;
  localparam int         N_DATA_SLOTS = 5;
  localparam int         N_SLOTS      = 8;
  localparam int         TIMER_W      = 28;

  // Slot whose sample triggers the frame check (the 111111 slot).
  localparam logic [2:0] K_CHECK = 3'(N_SLOTS - 2);

endpackage

// File: rtl/led_slot_timer.sv
// Saturating frame timer with slot sample-point generation and the
// end-of-frame sync window flag.
module led_slot_timer
  import led_frame_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES      = 25_000_000,
  parameter int unsigned LAST_SLOT_CYCLES = 25_000_001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart_i,
  output logic       sample_o,
  output logic [2:0] k_o,
  output logic       expired_o
);

  localparam logic [TIMER_W-1:0] FIRST_PT = TIMER_W'(LAST_SLOT_CYCLES + SLOT_CYCLES / 2);
  localparam logic [TIMER_W-1:0] STEP     = TIMER_W'(SLOT_CYCLES);
  localparam logic [TIMER_W-1:0] WIN_END  = TIMER_W'(LAST_SLOT_CYCLES + 7 * SLOT_CYCLES + SLOT_CYCLES / 2);
  localparam logic [2:0]         K_DONE   = 3'(N_SLOTS - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] pt_q, pt_d;
  logic [2:0]         k_q, k_d;

  assign sample_o  = (timer_q == pt_q) && (k_q != K_DONE);
  assign k_o       = k_q;
  assign expired_o = (timer_q >= WIN_END);

  // Restart marks the sync cycle as t=0, so the following cycle reads t=1.
  // Sample points are tracked incrementally to avoid a divider.
  always_comb begin
    timer_d = timer_q;
    pt_d    = pt_q;
    k_d     = k_q;
    if (restart_i) begin
      timer_d = TIMER_W'(1);
      pt_d    = FIRST_PT;
      k_d     = '0;
    end else begin
      if (timer_q != '1) timer_d = timer_q + 1'b1;
      if (sample_o) begin
        pt_d = pt_q + STEP;
        k_d  = k_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      pt_q    <= FIRST_PT;
      k_q     <= '0;
    end else begin
      timer_q <= timer_d;
      pt_q    <= pt_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: rtl/led_frame_decoder.sv
// Recovers a 30-bit count from an active-low, 8-slot LED frame stream,
// tracking frame sync and flagging malformed or missing frames.
module led_frame_decoder
  import led_frame_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES      = 25_000_000,
  parameter int unsigned LAST_SLOT_CYCLES = 25_000_001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  led_in,
  output logic [29:0] count_out,
  output logic        count_valid,
  output logic        frame_err,
  output logic        locked
);

  localparam logic [TIMER_W-1:0] RUN_MIN = TIMER_W'(SLOT_CYCLES / 2);

  state_e             state_q, state_d;
  logic [5:0]         led_q;
  logic [TIMER_W-1:0] run_q, run_d;
  logic [5:0]         samp_q [N_DATA_SLOTS+1];
  logic [29:0]        count_q, count_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               locked_q, locked_d;
  logic               restart, strobe, expired;
  logic [2:0]         slot_k;
  logic               sync_edge, hi_to_lo;

  // run_q counts consecutive 3F cycles preceding the current led_q.
  assign run_d     = (led_q != SYNC_HI) ? '0 : ((run_q == '1) ? run_q : run_q + 1'b1);
  assign sync_edge = (led_q == SYNC_LO) && (run_q >= RUN_MIN);
  assign hi_to_lo  = (led_q == SYNC_LO) && (run_q != '0);

  led_slot_timer #(
    .SLOT_CYCLES      (SLOT_CYCLES),
    .LAST_SLOT_CYCLES (LAST_SLOT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .sample_o  (strobe),
    .k_o       (slot_k),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    count_d  = count_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    case (state_q)
      HUNT: begin
        if (sync_edge) begin
          restart = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (strobe && slot_k == K_CHECK) begin
          if (samp_q[N_DATA_SLOTS] == SYNC_LO && led_q == SYNC_HI) begin
            count_d  = ~{samp_q[0], samp_q[1], samp_q[2], samp_q[3], samp_q[4]};
            valid_d  = 1'b1;
            locked_d = 1'b1;
            state_d  = SYNCW;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = HUNT;
          end
        end
      end
      SYNCW: begin
        if (hi_to_lo) begin
          restart = 1'b1;
          state_d = RECV;
        end else if (expired) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      led_q    <= '0;
      run_q    <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      for (int i = 0; i <= N_DATA_SLOTS; i++) samp_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_in;
      run_q    <= run_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      for (int i = 0; i <= N_DATA_SLOTS; i++) begin
        if (state_q == RECV && strobe && slot_k == 3'(i)) samp_q[i] <= led_q;
      end
    end
  end

  assign count_out   = count_q;
  assign count_valid = valid_q;
  assign frame_err   = err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_led_frame_decoder.sv
// Self-checking bench: frame table, random frames and corner sequences,
// checked each cycle against a history-based frame model.
module tb_led_frame_decoder;

  localparam int SLOT  = 8;
  localparam int LAST  = 9;
  localparam int HALF  = SLOT / 2;
  localparam int FRAME = LAST + 7 * SLOT;
  localparam int WIN   = LAST + 7 * SLOT + HALF;
  localparam int M_HUNT = 0, M_RECV = 1, M_SYNCW = 2;
  localparam int HMAX = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  led_in = '0;
  logic [29:0] count_out;
  logic        count_valid, frame_err, locked;

  led_frame_decoder #(.SLOT_CYCLES(SLOT), .LAST_SLOT_CYCLES(LAST)) dut (
    .clk         (clk),
    .rst         (rst),
    .led_in      (led_in),
    .count_out   (count_out),
    .count_valid (count_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nval, nerr;

  // Model: hist[c] is the registered LED value during cycle c.
  logic [5:0]  hist [HMAX];
  int          cyc = 0, rst_mark = 0, t0 = 0, mmode = M_HUNT;
  logic [29:0] e_cnt = '0;
  logic        e_val = 1'b0, e_err = 1'b0, e_lock = 1'b0;

  function automatic int pt(input int k);
    return LAST + k * SLOT + HALF;
  endfunction

  function automatic int run_before(input int c);
    int n = 0;
    for (int j = c - 1; j >= rst_mark && n < HALF; j--) begin
      if (hist[j] == 6'h3F) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_edge(input logic [5:0] v, input logic r);
    logic [5:0] lq;
    int t;
    e_val = 1'b0;
    e_err = 1'b0;
    if (r) begin
      mmode = M_HUNT; e_cnt = '0; e_lock = 1'b0;
      cyc++; hist[cyc] = 6'h00; rst_mark = cyc;
    end else begin
      lq = hist[cyc];
      t  = cyc - t0;
      case (mmode)
        M_HUNT: if (lq == 6'h00 && run_before(cyc) >= HALF) begin mmode = M_RECV; t0 = cyc; end
        M_RECV: if (t == pt(6)) begin
          if (hist[t0 + pt(5)] == 6'h00 && lq == 6'h3F) begin
            e_cnt = ~{hist[t0 + pt(0)], hist[t0 + pt(1)], hist[t0 + pt(2)], hist[t0 + pt(3)], hist[t0 + pt(4)]};
            e_val = 1'b1; e_lock = 1'b1; mmode = M_SYNCW;
          end else begin
            e_err = 1'b1; e_lock = 1'b0; mmode = M_HUNT;
          end
        end
        M_SYNCW: begin
          if (lq == 6'h00 && cyc - 1 >= rst_mark && hist[cyc - 1] == 6'h3F) begin
            mmode = M_RECV; t0 = cyc;
          end else if (t >= WIN) begin
            e_err = 1'b1; e_lock = 1'b0; mmode = M_HUNT;
          end
        end
        default: mmode = M_HUNT;
      endcase
      cyc++; hist[cyc] = v;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input logic [5:0] v, input logic r);
    led_in = v;
    rst    = r;
    @(posedge clk);
    if (cyc >= HMAX - 2) begin
      $display("FAIL history_overflow got %0d expected below %0d", cyc, HMAX - 2);
      $fatal(1);
    end
    model_edge(v, r);
    @(negedge clk);
    checks++;
    if ({count_valid, frame_err, locked, count_out} !== {e_val, e_err, e_lock, e_cnt}) begin
      errors++;
      $display("FAIL cycle %0d got valid=%b err=%b locked=%b count=%h expected valid=%b err=%b locked=%b count=%h",
               cyc, count_valid, frame_err, locked, count_out, e_val, e_err, e_lock, e_cnt);
    end
    if (count_valid === 1'b1) nval++;
    if (frame_err === 1'b1) nerr++;
    $display("cyc %0d led_in=%h rst=%b valid=%b err=%b locked=%b count=%h",
             cyc, v, r, count_valid, frame_err, locked, count_out);
  endtask

  task automatic send_frame(input int pre, input logic [29:0] cnt, input logic [5:0] s5,
                            input logic [5:0] s6, input int rst_at);
    logic [5:0] v;
    int slot;
    for (int i = 0; i < pre; i++) step(6'h3F, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      if (i < LAST) v = 6'h00;
      else if (i < LAST + 5 * SLOT) begin
        slot = (i - LAST) / SLOT;
        v = ~6'(cnt >> (6 * (4 - slot)));
      end else if (i < LAST + 6 * SLOT) v = s5;
      else v = s6;
      step(v, i == rst_at);
    end
  endtask

  typedef struct {
    int          pre;
    logic [29:0] cnt;
    logic [5:0]  s5;
    logic [5:0]  s6;
    int          rst_at;
    int          ev;
    int          ee;
    logic [29:0] ecnt;
    logic        elock;
  } row_t;

  row_t rows [9];

  initial begin
    logic [29:0] rc;
    logic [5:0]  r5, r6;

    rows[0] = '{6,  30'h0ABCDEF1, 6'h00, 6'h3F, -1, 1, 0, 30'h0ABCDEF1, 1'b1};
    rows[1] = '{0,  30'h0ABCDEF1, 6'h00, 6'h3F, -1, 1, 0, 30'h0ABCDEF1, 1'b1};
    rows[2] = '{0,  30'h12345678, 6'h01, 6'h3F, -1, 0, 1, 30'h0ABCDEF1, 1'b0};
    rows[3] = '{0,  30'h3FFFFFFF, 6'h00, 6'h3F, -1, 1, 0, 30'h3FFFFFFF, 1'b1};
    rows[4] = '{0,  30'h00000000, 6'h00, 6'h3F, -1, 1, 0, 30'h00000000, 1'b1};
    rows[5] = '{0,  30'h15555555, 6'h00, 6'h3F, -1, 1, 0, 30'h15555555, 1'b1};
    rows[6] = '{20, 30'h12345678, 6'h00, 6'h3F, -1, 1, 1, 30'h12345678, 1'b1};
    rows[7] = '{0,  30'h2AAAAAAA, 6'h00, 6'h3F, 31, 0, 0, 30'h00000000, 1'b0};
    rows[8] = '{0,  30'h0ABCDEF1, 6'h00, 6'h3F, -1, 1, 0, 30'h0ABCDEF1, 1'b1};

    @(negedge clk);
    step(6'h00, 1'b1);
    step(6'h00, 1'b1);
    chk("reset_count", {2'b0, count_out}, 32'h0);
    chk("reset_flags", {29'b0, count_valid, frame_err, locked}, 32'h0);

    for (int r = 0; r < 9; r++) begin
      nval = 0; nerr = 0;
      send_frame(rows[r].pre, rows[r].cnt, rows[r].s5, rows[r].s6, rows[r].rst_at);
      chk($sformatf("row%0d_valid_pulses", r), nval, rows[r].ev);
      chk($sformatf("row%0d_err_pulses", r), nerr, rows[r].ee);
      chk($sformatf("row%0d_count", r), {2'b0, count_out}, {2'b0, rows[r].ecnt});
      chk($sformatf("row%0d_locked", r), {31'b0, locked}, {31'b0, rows[r].elock});
    end

    for (int r = 0; r < 10; r++) begin
      rc = 30'($urandom);
      r5 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      r6 = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 62)) : 6'h3F;
      send_frame(0, rc, r5, r6, -1);
    end

    // Short 3F runs in HUNT must never be taken as sync.
    step(6'h00, 1'b1);
    nval = 0; nerr = 0;
    for (int i = 0; i < 3; i++) step(6'h3F, 1'b0);
    for (int i = 0; i < 4; i++) step(6'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(6'h3F, 1'b0);
    for (int i = 0; i < 70; i++) step(6'h15, 1'b0);
    chk("short_run_valid", nval, 0);
    chk("short_run_err", nerr, 0);
    chk("short_run_locked", {31'b0, locked}, 32'h0);

    // A real sync edge followed by garbage fails the check.
    nval = 0; nerr = 0;
    for (int i = 0; i < 5; i++) step(6'h3F, 1'b0);
    step(6'h00, 1'b0);
    for (int i = 0; i < 70; i++) step(6'h15, 1'b0);
    chk("false_sync_err", nerr, 1);
    chk("false_sync_valid", nval, 0);

    // Relock, then hold 3F so the sync window expires.
    nval = 0; nerr = 0;
    send_frame(6, 30'h0ABCDEF1, 6'h00, 6'h3F, -1);
    chk("relock_valid", nval, 1);
    chk("relock_count", {2'b0, count_out}, 32'h0ABCDEF1);
    chk("relock_locked", {31'b0, locked}, 32'h1);
    nerr = 0;
    for (int i = 0; i < 10; i++) step(6'h3F, 1'b0);
    chk("missing_sync_err", nerr, 1);
    chk("missing_sync_locked", {31'b0, locked}, 32'h0);
    chk("missing_sync_count", {2'b0, count_out}, 32'h0ABCDEF1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
